// File: rtl/prior_req_capture_4_pkg.sv
// Shared widths and the 4-input priority encoder used by the capture stage.
package prior_req_capture_4_pkg;

  localparam int ENC_W = 4;
  localparam int IDX_W = 2;

  // Returns {idx, valid}; bit 3 has the highest priority.
  function automatic logic [IDX_W:0] prior_enc4(input logic [ENC_W-1:0] req);
    logic [IDX_W-1:0] idx;
    idx = 2'b00;
    if (req[3])      idx = 2'b11;
    else if (req[2]) idx = 2'b10;
    else if (req[1]) idx = 2'b01;
    return {idx, |req};
  endfunction

endpackage

// File: rtl/prior_req_capture_4_sync_bit.sv
// Multi-flop synchroniser for one asynchronous request line.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/prior_req_capture_4.sv
// Captures request edges as sticky pending bits and presents the highest-priority
// pending index through a registered valid/ready output.
module prior_req_capture_4
  import prior_req_capture_4_pkg::*;
#(
  parameter int SYNC_STAGES = 2  // legal range 2..4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ENC_W-1:0] D,
  input  logic             ready,
  input  logic             ovf_clr,
  output logic             x,
  output logic             y,
  output logic             V,
  output logic [ENC_W-1:0] pending,
  output logic [ENC_W-1:0] ovf
);

  logic [ENC_W-1:0] s;
  logic [ENC_W-1:0] prev;
  logic [ENC_W-1:0] set;
  logic [ENC_W-1:0] clr;
  logic [ENC_W-1:0] m;
  logic [IDX_W:0]   enc;
  logic             acc;
  logic             load;

  for (genvar g = 0; g < ENC_W; g++) begin : g_sync
    sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (D[g]),
      .q   (s[g])
    );
  end

  // prev resets low, so a line held high through reset yields exactly one event.
  always_ff @(posedge clk) begin
    if (rst) prev <= '0;
    else     prev <= s;
  end

  assign set  = s & ~prev;
  assign acc  = V & ready;
  assign clr  = acc ? (ENC_W'(1) << {x, y}) : '0;
  assign m    = pending & ~clr;
  assign enc  = prior_enc4(m);
  assign load = ~V | acc;

  // set is OR-ed after the clear, so a same-cycle re-arm keeps the bit pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      ovf     <= '0;
    end else begin
      pending <= (pending & ~clr) | set;
      ovf     <= (ovf & ~{ENC_W{ovf_clr}}) | (set & pending & ~clr);
    end
  end

  // No preemption: a presented index holds until it is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      x <= 1'b0;
      y <= 1'b0;
      V <= 1'b0;
    end else if (load) begin
      {x, y} <= enc[IDX_W:1];
      V      <= enc[0];
    end
  end

endmodule

// File: tb/tb_prior_req_capture_4.sv
// Directed bench for prior_req_capture_4 with immediate-assertion checks.
module tb_prior_req_capture_4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] D;
  logic       ready;
  logic       ovf_clr;
  logic       x, y, V;
  logic [3:0] pending;
  logic [3:0] ovf;

  int n_cmp = 0;
  int n_err = 0;
  int deliv [4];

  prior_req_capture_4 #(.SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .D       (D),
    .ready   (ready),
    .ovf_clr (ovf_clr),
    .x       (x),
    .y       (y),
    .V       (V),
    .pending (pending),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 4; i++) deliv[i] = 0;
  end

  // Scoreboard: count handshake deliveries per index.
  always @(posedge clk) begin
    if (!rst && V && ready) deliv[{x, y}] = deliv[{x, y}] + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v_exp, input logic [1:0] idx_exp);
    chk(tag, {1'b0, V, x, y}, {1'b0, v_exp, idx_exp});
  endtask

  task automatic settle();
    D = 4'b0000; ready = 1'b0; ovf_clr = 1'b0;
    tick(4);
  endtask

  initial begin
    // 1: reset with all lines high
    rst = 1'b1; D = 4'b1111; ready = 1'b0; ovf_clr = 1'b0;
    tick();
    chk_out("rst_out_c1", 1'b0, 2'b00);
    chk("rst_pend_c1", pending, 4'b0000);
    tick();
    chk_out("rst_out_c2", 1'b0, 2'b00);
    chk("rst_pend_c2", pending, 4'b0000);
    chk("rst_ovf", ovf, 4'b0000);
    rst = 1'b0;
    tick(2);
    chk("rel_pend_c2", pending, 4'b0000);
    tick();
    chk("rel_pend_c3", pending, 4'b1111);
    chk_out("rel_out_c3", 1'b0, 2'b00);
    ready = 1'b1;
    tick();
    chk_out("drain_3", 1'b1, 2'b11);
    tick();
    chk_out("drain_2", 1'b1, 2'b10);
    chk("drain_pend_2", pending, 4'b0111);
    tick();
    chk_out("drain_1", 1'b1, 2'b01);
    tick();
    chk_out("drain_0", 1'b1, 2'b00);
    tick();
    chk_out("drain_done", 1'b0, 2'b00);
    chk("drain_pend", pending, 4'b0000);
    settle();

    // 2: single event on bit 2, consumer always ready
    D = 4'b0100; ready = 1'b1;
    tick(3);
    chk_out("single_pre", 1'b0, 2'b00);
    chk("single_pend", pending, 4'b0100);
    D = 4'b0000;
    tick();
    chk_out("single_v", 1'b1, 2'b10);
    tick();
    chk_out("single_once", 1'b0, 2'b00);
    chk("single_pend0", pending, 4'b0000);
    chk("single_ovf", ovf, 4'b0000);
    settle();

    // 3: priority and backpressure
    D = 4'b0101;
    tick(3);
    D = 4'b0000;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk_out("bp_hold", 1'b1, 2'b10);
    end
    ready = 1'b1;
    tick();
    chk_out("bp_next", 1'b1, 2'b00);
    tick();
    chk_out("bp_empty", 1'b0, 2'b00);
    settle();

    // 4: no preemption by a higher request
    D = 4'b0001;
    tick(3);
    D = 4'b0000;
    tick();
    chk_out("np_idx0", 1'b1, 2'b00);
    D = 4'b1000;
    tick(3);
    D = 4'b0000;
    tick();
    chk_out("np_hold", 1'b1, 2'b00);
    chk("np_pend", pending, 4'b1001);
    ready = 1'b1;
    tick();
    chk_out("np_idx3", 1'b1, 2'b11);
    tick();
    chk_out("np_empty", 1'b0, 2'b00);
    settle();

    // 5: overflow on bit 1
    D = 4'b0010;
    tick(2);
    D = 4'b0000;
    tick(2);
    chk_out("ovf_v", 1'b1, 2'b01);
    D = 4'b0010;
    tick(2);
    D = 4'b0000;
    tick();
    chk("ovf_set", ovf, 4'b0010);
    chk("ovf_pend", pending, 4'b0010);
    ready = 1'b1;
    tick();
    chk_out("ovf_one_deliv", 1'b0, 2'b00);
    chk("ovf_sticky", ovf, 4'b0010);
    ready = 1'b0;
    D = 4'b0010;
    tick(2);
    D = 4'b0000;
    tick(2);
    D = 4'b0010;
    tick(2);
    D = 4'b0000; ovf_clr = 1'b1;
    tick();
    chk("ovf_set_wins", ovf, 4'b0010);
    tick();
    chk("ovf_cleared", ovf, 4'b0000);
    ovf_clr = 1'b0; ready = 1'b1;
    tick();
    chk_out("ovf_drain", 1'b0, 2'b00);
    settle();

    // 6: set/clear collision on bit 2
    D = 4'b0100;
    tick(2);
    D = 4'b0000;
    tick(2);
    chk_out("col_v", 1'b1, 2'b10);
    D = 4'b0100;
    tick(2);
    D = 4'b0000; ready = 1'b1;
    tick();
    chk("col_pend", pending, 4'b0100);
    chk("col_ovf", ovf, 4'b0000);
    chk_out("col_gap", 1'b0, 2'b00);
    tick();
    chk_out("col_again", 1'b1, 2'b10);
    tick();
    chk_out("col_done", 1'b0, 2'b00);
    settle();

    // reset mid-transfer discards pending state
    D = 4'b0011;
    tick(4);
    chk_out("mid_v", 1'b1, 2'b01);
    rst = 1'b1; D = 4'b0000;
    tick();
    chk("mid_pend", pending, 4'b0000);
    chk_out("mid_out", 1'b0, 2'b00);
    rst = 1'b0;
    tick(3);

    chk("deliv_0", 4'(deliv[0]), 4'd3);
    chk("deliv_1", 4'(deliv[1]), 4'd3);
    chk("deliv_2", 4'(deliv[2]), 4'd5);
    chk("deliv_3", 4'(deliv[3]), 4'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
